// File: rtl/motor_sched_pkg.sv
// Shared types and constants for the two-axis motor step scheduler.
// State encoding, axis/direction codes and a small sizing helper.
package motor_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEAD,
        RUN
    } state_t;

    localparam logic AXIS_THETA = 1'b0;
    localparam logic AXIS_PHI   = 1'b1;
    localparam logic DIR_POS    = 1'b0;
    localparam logic DIR_NEG    = 1'b1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/motor_axis_scheduler_step_timer.sv
// Loadable down-counter shared by the dead-time and step-pacing phases.
// Ports: clk, rst (sync, active-high), i_load/i_load_val, i_dec, o_zero.
module step_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/motor_axis_scheduler.sv
// Grants theta/phi one at a time onto a shared driver, emits paced step
// pulses with dead time on axis/dir change and a per-grant burst cap.
// Ports: clk, rst (sync, active-high), enable, req_{theta,phi}_{pos,neg} in;
//        step_{theta,phi}_{pos,neg}, busy, grant_axis, step_cnt[7:0], fault out.
module motor_axis_scheduler
    import motor_sched_pkg::*;
#(
    parameter int STEP_DIV  = 50000,
    parameter int DEAD_CYC  = 1000,
    parameter int MAX_STEPS = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       req_theta_pos,
    input  logic       req_theta_neg,
    input  logic       req_phi_pos,
    input  logic       req_phi_neg,
    output logic       step_theta_pos,
    output logic       step_theta_neg,
    output logic       step_phi_pos,
    output logic       step_phi_neg,
    output logic       busy,
    output logic       grant_axis,
    output logic [7:0] step_cnt,
    output logic       fault
);

    localparam int              TW      = $clog2(max2(STEP_DIV, DEAD_CYC));
    localparam logic [TW-1:0]   STEP_LD = TW'(STEP_DIV - 1);
    localparam logic [TW-1:0]   DEAD_LD = TW'(DEAD_CYC - 1);
    localparam logic [7:0]      MAX_CNT = 8'(MAX_STEPS);

    state_t     r_state;
    logic       r_axis;
    logic       r_dir;
    logic       r_last_axis;
    logic       r_last_dir;
    logic       r_last_valid;
    logic [3:0] r_step;
    logic       r_busy;
    logic [7:0] r_cnt;
    logic       r_fault;

    logic          w_val_t;
    logic          w_val_p;
    logic          w_any;
    logic          w_conf;
    logic          w_axis;
    logic          w_dir;
    logic          w_same;
    logic          w_pos;
    logic          w_neg;
    logic          w_hold;
    logic          w_zero;
    logic          w_ld;
    logic [TW-1:0] w_ld_val;
    logic          w_dec;

    assign w_val_t = req_theta_pos ^ req_theta_neg;
    assign w_val_p = req_phi_pos ^ req_phi_neg;
    assign w_any   = w_val_t | w_val_p;
    assign w_conf  = (req_theta_pos & req_theta_neg) |
                     (req_phi_pos & req_phi_neg);

    // Both axes valid: hand the grant to the one not served last.
    assign w_axis = (w_val_t & w_val_p) ? ~r_last_axis : w_val_p;
    assign w_dir  = (w_axis == AXIS_PHI) ? req_phi_neg : req_theta_neg;
    assign w_same = r_last_valid & (w_axis == r_last_axis) &
                    (w_dir == r_last_dir);

    // Granted request must still be asserted alone in the granted direction.
    assign w_pos  = r_axis ? req_phi_pos : req_theta_pos;
    assign w_neg  = r_axis ? req_phi_neg : req_theta_neg;
    assign w_hold = r_dir ? (w_neg & ~w_pos) : (w_pos & ~w_neg);

    always_comb begin
        w_ld     = 1'b0;
        w_ld_val = '0;
        w_dec    = 1'b0;
        if (!enable) begin
            w_ld = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        w_ld     = 1'b1;
                        w_ld_val = w_same ? STEP_LD : DEAD_LD;
                    end
                end
                DEAD, RUN: begin
                    if (!w_hold) begin
                        w_ld = 1'b1;
                    end else if (w_zero) begin
                        w_ld     = 1'b1;
                        w_ld_val = STEP_LD;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    step_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_ld),
        .i_load_val (w_ld_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_axis       <= AXIS_THETA;
            r_dir        <= DIR_POS;
            r_last_axis  <= AXIS_PHI;
            r_last_dir   <= DIR_POS;
            r_last_valid <= 1'b0;
            r_step       <= '0;
            r_busy       <= 1'b0;
            r_cnt        <= '0;
            r_fault      <= 1'b0;
        end else if (!enable) begin
            r_state <= IDLE;
            r_axis  <= AXIS_THETA;
            r_step  <= '0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_step <= '0;
            if (w_conf) begin
                r_fault <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state      <= w_same ? RUN : DEAD;
                        r_axis       <= w_axis;
                        r_dir        <= w_dir;
                        r_cnt        <= '0;
                        r_busy       <= 1'b1;
                        r_last_axis  <= w_axis;
                        r_last_dir   <= w_dir;
                        r_last_valid <= 1'b1;
                    end
                end
                DEAD: begin
                    if (!w_hold) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_zero) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!w_hold) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_zero) begin
                        // One-hot order: theta+, theta-, phi+, phi-.
                        r_step <= 4'b1000 >> {r_axis, r_dir};
                        r_cnt  <= r_cnt + 8'd1;
                        if (r_cnt + 8'd1 == MAX_CNT) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign step_theta_pos = r_step[3];
    assign step_theta_neg = r_step[2];
    assign step_phi_pos   = r_step[1];
    assign step_phi_neg   = r_step[0];
    assign busy           = r_busy;
    assign grant_axis     = r_axis;
    assign step_cnt       = r_cnt;
    assign fault          = r_fault;

endmodule

// File: tb/tb_motor_axis_scheduler.sv
// Scoreboard bench for motor_axis_scheduler (STEP_DIV=4, DEAD_CYC=3,
// MAX_STEPS=3): timeline reference model feeds a queue, monitor compares.
module tb_motor_axis_scheduler;

    localparam int SD = 4;
    localparam int DC = 3;
    localparam int MS = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       rtp, rtn, rpp, rpn;
    logic       stp, stn, spp, spn;
    logic       busy, gax, fault;
    logic [7:0] scnt;

    always #5 clk = ~clk;

    motor_axis_scheduler #(
        .STEP_DIV  (SD),
        .DEAD_CYC  (DC),
        .MAX_STEPS (MS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .req_theta_pos  (rtp),
        .req_theta_neg  (rtn),
        .req_phi_pos    (rpp),
        .req_phi_neg    (rpn),
        .step_theta_pos (stp),
        .step_theta_neg (stn),
        .step_phi_pos   (spp),
        .step_phi_neg   (spn),
        .busy           (busy),
        .grant_axis     (gax),
        .step_cnt       (scnt),
        .fault          (fault)
    );

    typedef struct {
        int         cyc;
        logic [3:0] vec;
    } pulse_t;

    pulse_t exp_q[$];
    int     obs_q[$];
    int     cyc    = 0;
    int     n_cmp  = 0;
    int     n_bad  = 0;

    // Reference: a grant is a window with an absolute due time for the
    // next pulse; nothing here counts down.
    bit m_busy = 0, m_fault = 0, m_axis = 0, m_dir = 0;
    bit m_last_axis = 1, m_last_dir = 0, m_last_valid = 0;
    int m_cnt = 0, m_due = 0;

    function automatic logic [3:0] code(input bit a, input bit d);
        return {!a && !d, !a && d, a && !d, a && d};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 20)
                $display("FAIL %s cyc=%0d got=%0d want=%0d",
                         name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin : p_model
        bit vt, vp, ax, dr, p, n, ok;
        cyc++;
        if (rst) begin
            m_busy = 0; m_fault = 0; m_axis = 0; m_cnt = 0;
            m_last_axis = 1; m_last_valid = 0;
        end else if (!enable) begin
            m_busy = 0; m_fault = 0; m_axis = 0; m_cnt = 0;
        end else begin
            if ((rtp && rtn) || (rpp && rpn)) m_fault = 1;
            vt = rtp ^ rtn;
            vp = rpp ^ rpn;
            if (m_busy) begin
                p  = m_axis ? rpp : rtp;
                n  = m_axis ? rpn : rtn;
                ok = m_dir ? (n && !p) : (p && !n);
                if (!ok) begin
                    m_busy = 0;
                end else if (cyc == m_due) begin
                    exp_q.push_back('{cyc: cyc, vec: code(m_axis, m_dir)});
                    m_cnt++;
                    m_due = cyc + SD;
                    if (m_cnt == MS) m_busy = 0;
                end
            end else if (vt || vp) begin
                ax = (vt && vp) ? !m_last_axis : vp;
                dr = ax ? rpn : rtn;
                m_due = cyc + SD;
                if (!(m_last_valid && ax == m_last_axis && dr == m_last_dir))
                    m_due += DC;
                m_busy = 1; m_axis = ax; m_dir = dr; m_cnt = 0;
                m_last_axis = ax; m_last_dir = dr; m_last_valid = 1;
            end
        end
    end

    always @(negedge clk) begin : p_mon
        logic [3:0] v, e;
        v = {stp, stn, spp, spn};
        e = '0;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc)
            e = exp_q.pop_front().vec;
        if (v != 0) obs_q.push_back(cyc);
        chk("step_vec", int'(v), int'(e));
        chk("busy", int'(busy), int'(m_busy));
        chk("fault", int'(fault), int'(m_fault));
        chk("step_cnt", int'(scnt), m_cnt);
        chk("grant_axis", int'(gax), int'(m_axis));
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    int base;
    int t1_exp[4] = '{7, 11, 15, 20};

    initial begin
        rst = 1; enable = 1;
        {rtp, rtn, rpp, rpn} = '0;
        tick(3);
        rst = 0;

        // T1: first pulse after dead + step, re-grant without dead time.
        obs_q.delete();
        base = cyc + 1;
        rtp  = 1;
        tick(25);
        for (int i = 0; i < 4; i++)
            chk("t1_pulse_time",
                (i < obs_q.size()) ? obs_q[i] - base : -1, t1_exp[i]);
        rtp = 0;
        tick(6);

        // T2: alternating grants.
        rtp = 1; rpn = 1;
        tick(50);
        rtp = 0; rpn = 0;
        tick(4);

        // T3: theta conflict, phi served.
        rtp = 1; rtn = 1; rpp = 1;
        tick(20);

        // T6: enable low while phi waits in dead time with fault set.
        rpp = 0;
        tick(3);
        rtp = 0; rtn = 0; rpn = 1;
        tick(2);
        enable = 0;
        tick(3);
        rpn = 0; enable = 1;
        tick(4);

        // T4: drop on the cycle of the second timer expiry.
        rtp = 1;
        tick(11);
        rtp = 0;
        tick(5);

        // T5: reset in RUN, then full dead time again.
        rtp = 1;
        tick(10);
        rst = 1;
        tick(1);
        rst = 0;
        tick(15);
        rtp = 0;

        obs_q.delete();
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(23))
                0: rtp = ~rtp;
                1: rtn = ~rtn;
                2: rpp = ~rpp;
                3: rpn = ~rpn;
                default: ;
            endcase
            enable = ($urandom_range(249) != 0);
            rst    = ($urandom_range(399) == 0);
            tick(1);
        end
        rst = 0; enable = 1;
        tick(3);
        chk("random_pulses_seen", int'(obs_q.size() > 20), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
